// File: rtl/game_defs.sv
// game_defs: shared direction codes, hitbox sizes, position helpers and FSM encodings
package game_defs;
   localparam logic [2:0] DIR_NONE  = 3'd0;
   localparam logic [2:0] DIR_UP    = 3'd1;
   localparam logic [2:0] DIR_DOWN  = 3'd2;
   localparam logic [2:0] DIR_LEFT  = 3'd3;
   localparam logic [2:0] DIR_RIGHT = 3'd4;
   localparam int HIT_SPAN  = 16;
   localparam int HIT_REACH = 19;
   localparam int POS_W     = 20;
   localparam int COORD_W   = 10;
   localparam int DIFF_W    = COORD_W + 1;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SCAN    = 2'd1;
   localparam logic [1:0] ST_PUBLISH = 2'd2;
   function automatic logic [DIFF_W-1:0] pos_x(input logic [POS_W-1:0] p);
      return {1'b0, p[POS_W-1:COORD_W]};
   endfunction
   function automatic logic [DIFF_W-1:0] pos_y(input logic [POS_W-1:0] p);
      return {1'b0, p[COORD_W-1:0]};
   endfunction
endpackage

// File: rtl/collision_check.sv
// collision_check: combinational player/enemy hitbox test returning a direction code
module collision_check
   import game_defs::*;
(
   input  logic [19:0] player_pos,
   input  logic [19:0] enemy_pos,
   output logic [2:0]  dir
);
   logic [DIFF_W-1:0] w_px, w_py, w_ex, w_ey, w_adx, w_ady;
   logic w_xnear, w_ynear, w_down, w_up, w_right, w_left;
   assign w_px = pos_x(player_pos);
   assign w_py = pos_y(player_pos);
   assign w_ex = pos_x(enemy_pos);
   assign w_ey = pos_y(enemy_pos);
   assign w_adx = (w_ex >= w_px) ? w_ex - w_px : w_px - w_ex;
   assign w_ady = (w_ey >= w_py) ? w_ey - w_py : w_py - w_ey;
   assign w_xnear = w_adx <= DIFF_W'(HIT_SPAN);
   assign w_ynear = w_ady <= DIFF_W'(HIT_SPAN);
   assign w_down  = (w_ey >= w_py) && (w_ey <= w_py + DIFF_W'(HIT_REACH));
   assign w_up    = (w_py >= w_ey) && (w_py <= w_ey + DIFF_W'(HIT_REACH));
   assign w_right = (w_ex >= w_px) && (w_ex <= w_px + DIFF_W'(HIT_REACH));
   assign w_left  = (w_px >= w_ex) && (w_px <= w_ex + DIFF_W'(HIT_REACH));
   assign dir = (w_xnear && w_down)  ? DIR_DOWN  :
                (w_xnear && w_up)    ? DIR_UP    :
                (w_ynear && w_right) ? DIR_RIGHT :
                (w_ynear && w_left)  ? DIR_LEFT  : DIR_NONE;
endmodule

// File: rtl/collision_scheduler.sv
// collision_scheduler: scans one enemy per clock against a frame snapshot and publishes hit results
module collision_scheduler
   import game_defs::*;
#(
   parameter int N_ENEMY = 8,
   parameter int IDX_W   = 4
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     frame_tick,
   input  logic [19:0]              player_pos,
   input  logic [N_ENEMY*20-1:0]    enemy_pos,
   input  logic [N_ENEMY-1:0]       enemy_active,
   output logic                     busy,
   output logic                     done,
   output logic [N_ENEMY-1:0]       hit_mask,
   output logic                     hit_any,
   output logic [IDX_W-1:0]         first_idx,
   output logic [2:0]               first_dir,
   output logic                     overrun
);
   logic [1:0]              r_state;
   logic [IDX_W-1:0]        r_idx;
   logic [19:0]             r_player;
   logic [N_ENEMY*20-1:0]   r_enemy;
   logic [N_ENEMY-1:0]      r_active;
   logic [N_ENEMY-1:0]      r_acc_mask;
   logic                    r_acc_found;
   logic [IDX_W-1:0]        r_acc_idx;
   logic [2:0]              r_acc_dir;
   logic                    r_busy, r_done, r_hit_any, r_overrun;
   logic [N_ENEMY-1:0]      r_hit_mask;
   logic [IDX_W-1:0]        r_first_idx;
   logic [2:0]              r_first_dir;
   logic [19:0]             w_enemy;
   logic [2:0]              w_dir_raw, w_dir;
   logic [N_ENEMY-1:0]      w_sel;
   logic                    w_last;
   assign w_sel   = N_ENEMY'(1) << r_idx;
   assign w_enemy = 20'(r_enemy >> (int'(r_idx) * POS_W));
   assign w_dir   = |(r_active & w_sel) ? w_dir_raw : DIR_NONE;
   assign w_last  = r_idx == IDX_W'(N_ENEMY - 1);
   collision_check u_check (
      .player_pos (r_player),
      .enemy_pos  (w_enemy),
      .dir        (w_dir_raw)
   );
   // Scan sequencer: snapshot on an accepted tick, accumulate one slot per clock, then publish
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_player    <= '0;
         r_enemy     <= '0;
         r_active    <= '0;
         r_acc_mask  <= '0;
         r_acc_found <= 1'b0;
         r_acc_idx   <= '0;
         r_acc_dir   <= DIR_NONE;
      end else if (r_state == ST_IDLE) begin
         if (frame_tick) begin
            r_state     <= ST_SCAN;
            r_idx       <= '0;
            r_player    <= player_pos;
            r_enemy     <= enemy_pos;
            r_active    <= enemy_active;
            r_acc_mask  <= '0;
            r_acc_found <= 1'b0;
            r_acc_idx   <= '0;
            r_acc_dir   <= DIR_NONE;
         end
      end else if (r_state == ST_SCAN) begin
         if (w_dir != DIR_NONE) begin
            r_acc_mask <= r_acc_mask | w_sel;
            if (!r_acc_found) begin
               r_acc_found <= 1'b1;
               r_acc_idx   <= r_idx;
               r_acc_dir   <= w_dir;
            end
         end
         r_state <= w_last ? ST_PUBLISH : ST_SCAN;
         r_idx   <= w_last ? r_idx : r_idx + 1'b1;
      end else begin
         r_state <= ST_IDLE;
      end
   end
   // Registered outputs; busy stays high through the done cycle so ticks there count as overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
         r_hit_mask  <= '0;
         r_hit_any   <= 1'b0;
         r_first_idx <= '0;
         r_first_dir <= DIR_NONE;
      end else begin
         r_busy    <= (r_state == ST_IDLE) ? frame_tick : 1'b1;
         r_done    <= r_state == ST_PUBLISH;
         r_overrun <= frame_tick && (r_state != ST_IDLE);
         if (r_state == ST_PUBLISH) begin
            r_hit_mask  <= r_acc_mask;
            r_hit_any   <= |r_acc_mask;
            r_first_idx <= r_acc_idx;
            r_first_dir <= r_acc_dir;
         end
      end
   end
   assign busy      = r_busy;
   assign done      = r_done;
   assign overrun   = r_overrun;
   assign hit_mask  = r_hit_mask;
   assign hit_any   = r_hit_any;
   assign first_idx = r_first_idx;
   assign first_dir = r_first_dir;
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler: directed checks of scan results, latency, overrun and reset abort
module tb_collision_scheduler;
   localparam int N = 8;
   logic clk = 1'b0;
   logic rst;
   logic frame_tick;
   logic [19:0] player_pos;
   logic [N*20-1:0] enemy_pos;
   logic [N-1:0] enemy_active;
   logic busy, done, hit_any, overrun;
   logic [N-1:0] hit_mask;
   logic [3:0] first_idx;
   logic [2:0] first_dir;
   int checks = 0;
   int failures = 0;
   always #5 clk = ~clk;
   collision_scheduler #(.N_ENEMY(N), .IDX_W(4)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .player_pos(player_pos),
      .enemy_pos(enemy_pos), .enemy_active(enemy_active), .busy(busy), .done(done),
      .hit_mask(hit_mask), .hit_any(hit_any), .first_idx(first_idx),
      .first_dir(first_dir), .overrun(overrun)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic set_e(input int i, input int x, input int y);
      enemy_pos[i*20 +: 20] = {10'(x), 10'(y)};
   endtask
   task automatic set_p(input int x, input int y);
      player_pos = {10'(x), 10'(y)};
   endtask
   task automatic far_all();
      for (int i = 0; i < N; i++) set_e(i, 600, 600);
   endtask
   task automatic pulse_tick();
      @(negedge clk) frame_tick = 1'b1;
      @(posedge clk);
      @(negedge clk) frame_tick = 1'b0;
   endtask
   task automatic scan(input string tag, input logic [7:0] m, input int idx, input int dir);
      pulse_tick();
      repeat (N) @(posedge clk);
      #1;
      chk({tag, "_pre_done"}, {30'd0, busy, done}, 32'h2);
      @(posedge clk);
      #1;
      chk({tag, "_done"}, {30'd0, busy, done}, 32'h3);
      chk({tag, "_mask"}, 32'(hit_mask), 32'(m));
      chk({tag, "_any"}, 32'(hit_any), 32'(m != 0));
      chk({tag, "_idx"}, 32'(first_idx), 32'(idx));
      chk({tag, "_dir"}, 32'(first_dir), 32'(dir));
      @(posedge clk);
      #1;
      chk({tag, "_idle"}, {30'd0, busy, done}, 32'h0);
   endtask
   initial begin
      bit seen_done;
      rst = 1'b1;
      frame_tick = 1'b0;
      enemy_active = '0;
      set_p(0, 0);
      far_all();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", {hit_mask, first_idx, first_dir, busy, done, hit_any, overrun}, 32'h0);
      @(negedge clk) rst = 1'b0;
      set_p(100, 100);
      set_e(0, 110, 110);
      enemy_active = 8'h01;
      scan("down_e0", 8'h01, 0, 2);
      enemy_active = 8'h00;
      scan("inactive_e0", 8'h00, 0, 0);
      far_all();
      enemy_active = 8'hFF;
      set_e(3, 130, 100);
      set_e(5, 100, 90);
      scan("up_e5", 8'h20, 5, 1);
      far_all();
      set_e(2, 118, 105);
      scan("right_e2", 8'h04, 2, 4);
      set_e(2, 82, 95);
      scan("left_e2", 8'h04, 2, 3);
      set_e(2, 115, 40);
      scan("miss_e2", 8'h00, 0, 0);
      set_e(2, 85, 110);
      scan("down_e2", 8'h04, 2, 2);
      far_all();
      set_e(1, 105, 95);
      set_e(6, 95, 112);
      scan("two_hits", 8'h42, 1, 1);
      far_all();
      set_p(0, 0);
      set_e(1, 1023, 0);
      scan("no_wrap", 8'h00, 0, 0);
      set_e(1, 16, 19);
      scan("edge_16_19", 8'h02, 1, 2);
      set_e(1, 17, 0);
      scan("edge_17_0", 8'h02, 1, 4);
      set_e(1, 17, 20);
      scan("edge_17_20", 8'h00, 0, 0);
      far_all();
      set_p(100, 100);
      set_e(0, 110, 110);
      enemy_active = 8'h01;
      pulse_tick();
      repeat (3) @(posedge clk);
      #1;
      set_e(0, 600, 600);
      @(negedge clk) frame_tick = 1'b1;
      @(posedge clk);
      #1;
      chk("overrun_pulse", 32'(overrun), 32'h1);
      @(negedge clk) frame_tick = 1'b0;
      @(posedge clk);
      #1;
      chk("overrun_clear", 32'(overrun), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("ovr_pre_done", {30'd0, busy, done}, 32'h2);
      @(negedge clk) frame_tick = 1'b1;
      @(posedge clk);
      #1;
      chk("ovr_done", {30'd0, busy, done}, 32'h3);
      chk("ovr_at_done", 32'(overrun), 32'h1);
      chk("snapshot_mask", 32'(hit_mask), 32'h01);
      chk("snapshot_dir", 32'(first_dir), 32'h2);
      @(negedge clk) frame_tick = 1'b0;
      @(posedge clk);
      #1;
      chk("tick_at_done_dropped", {30'd0, busy, done}, 32'h0);
      set_e(0, 110, 110);
      scan("restore", 8'h01, 0, 2);
      pulse_tick();
      repeat (4) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      #1;
      chk("rst_abort_outs", {hit_mask, first_idx, first_dir, busy, done, hit_any, overrun}, 32'h0);
      @(negedge clk) rst = 1'b0;
      seen_done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen_done = 1'b1;
      end
      chk("rst_no_done", 32'(seen_done), 32'h0);
      scan("after_rst", 8'h01, 0, 2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
